// File: rtl/flex_down_timer.sv
// Loadable down-counting timer: counts from a programmed value to zero, pulses on
// expiry, and optionally reloads for periodic strobes.
module flex_down_timer #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    periodic,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    busy,
  output logic                    expire_pulse,
  output logic                    zero_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_n;
  logic [NUM_CNT_BITS-1:0] reload;
  logic [NUM_CNT_BITS-1:0] reload_n;
  logic [NUM_CNT_BITS-1:0] count_n;
  logic                    pulse_n;

  // State and all registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      count_out    <= '0;
      reload       <= '0;
      busy         <= 1'b0;
      expire_pulse <= 1'b0;
      zero_flag    <= 1'b1;
    end else begin
      state        <= state_n;
      count_out    <= count_n;
      reload       <= reload_n;
      busy         <= (state_n != IDLE);
      expire_pulse <= pulse_n;
      zero_flag    <= (count_n == '0);
    end
  end

  // Next state, count and reload; clear > start > pause > decrement
  always_comb begin
    state_n  = state;
    count_n  = count_out;
    reload_n = reload;
    pulse_n  = 1'b0;

    if (clear) begin
      state_n  = IDLE;
      count_n  = '0;
      reload_n = '0;
    end else if (start) begin
      // A zero load value is rejected outright and freezes everything this edge
      if (load_val != '0) begin
        state_n  = RUN;
        count_n  = load_val;
        reload_n = load_val;
      end
    end else begin
      unique case (state)
        IDLE: ;
        RUN: begin
          if (pause) begin
            state_n = HOLD;
          end else if (count_out > NUM_CNT_BITS'(1)) begin
            count_n = count_out - NUM_CNT_BITS'(1);
          end else if (count_out == NUM_CNT_BITS'(1)) begin
            pulse_n = 1'b1;
            if (periodic) begin
              count_n = reload;
            end else begin
              count_n = '0;
              state_n = IDLE;
            end
          end else begin
            state_n = IDLE;
          end
        end
        HOLD: begin
          // Resume costs one edge; decrementing restarts on the following edge
          if (!pause) state_n = RUN;
        end
        default: begin
          state_n = IDLE;
          count_n = '0;
        end
      endcase
    end
  end

endmodule
